// File: rtl/nexys4_io_pkg.sv
// ---------------------------------------------------------------------------
// nexys4_io_pkg
// Shared constants for the Nexys4 word-entry path: digit count, cursor width,
// the two-state entry FSM encoding and the push-button index map used to
// address the debounced pulse vector.
// ---------------------------------------------------------------------------
package nexys4_io_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int CURSOR_W   = 3;

    typedef logic [CURSOR_W-1:0] cursor_t;

    // Entry FSM encoding, kept as plain constants so older tools can read it
    localparam logic [0:0] ST_EDIT   = 1'b0;
    localparam logic [0:0] ST_COMMIT = 1'b1;

    // Index of each button inside the pulse vector
    localparam int BTN_L    = 0;
    localparam int BTN_R    = 1;
    localparam int BTN_U    = 2;
    localparam int BTN_D    = 3;
    localparam int NUM_BTNS = 4;

endpackage

// File: rtl/nexys4_btn_debounce.sv
// ---------------------------------------------------------------------------
// nexys4_btn_debounce
// Conditions one raw push button: two-flop synchronizer, stability counter
// and a single-cycle pulse on each accepted press (release gives no pulse).
//
// Ports:
//   clk_in   board clock
//   reset    synchronous, active-high reset
//   btn_in   raw, asynchronous button level
//   pulse_o  one-cycle pulse per accepted 0->1 change of the debounced level
// ---------------------------------------------------------------------------
module nexys4_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic clk_in,
    input  logic reset,
    input  logic btn_in,
    output logic pulse_o
);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic             stablePrev_q;
    logic             pulse_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The counter only runs while the synced level disagrees with the stable
    // level; any agreement (including a bounce back) restarts the count, so
    // only an unbroken run of DEBOUNCE_CYCLES differing samples flips it.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Synchronizer, debounce state and a registered rise detector.  The
    // pulse is taken from the previous stable level so it is a clean flop
    // output one cycle after the stable level rises.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b0;
            stablePrev_q <= 1'b0;
            pulse_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= btn_in;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stablePrev_q <= stable_q;
            pulse_q      <= stable_q & ~stablePrev_q;
            cnt_q        <= cnt_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/nexys4_word_entry.sv
// ---------------------------------------------------------------------------
// nexys4_word_entry
// Builds a 32-bit hex word from the board switches and four push buttons and
// hands it to the miner core over a valid/ready handshake.
//
// Ports:
//   clk_in         board clock (100 MHz)
//   reset          synchronous, active-high reset
//   BTNL_in        cursor toward the most significant nibble (wraps 7->0)
//   BTNR_in        cursor toward the least significant nibble (wraps 0->7)
//   BTNU_in        write SW_in into the nibble under the cursor
//   BTND_in        commit the edit buffer to word_out
//   SW_in          hex digit to write
//   edit_word      live edit buffer for the display driver
//   cursor_onehot  one-hot cursor, bit i selects nibble i
//   word_out       committed word
//   word_valid     word_out is being offered
//   word_ready     consumer accepts word_out
// ---------------------------------------------------------------------------
module nexys4_word_entry
    import nexys4_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic                    clk_in,
    input  logic                    reset,
    input  logic                    BTNL_in,
    input  logic                    BTNR_in,
    input  logic                    BTNU_in,
    input  logic                    BTND_in,
    input  logic [3:0]              SW_in,
    output logic [4*NUM_DIGITS-1:0] edit_word,
    output logic [NUM_DIGITS-1:0]   cursor_onehot,
    output logic [4*NUM_DIGITS-1:0] word_out,
    output logic                    word_valid,
    input  logic                    word_ready
);

    logic [NUM_BTNS-1:0]     btnRaw;
    logic [NUM_BTNS-1:0]     btnPulse;

    logic [0:0]              state_q,        state_d;
    cursor_t                 cursor_q,       cursor_d;
    logic [NUM_DIGITS-1:0]   cursorOnehot_q, cursorOnehot_d;
    logic [4*NUM_DIGITS-1:0] editWord_q,     editWord_d;
    logic [4*NUM_DIGITS-1:0] wordOut_q,      wordOut_d;
    logic                    wordValid_q,    wordValid_d;

    assign btnRaw[BTN_L] = BTNL_in;
    assign btnRaw[BTN_R] = BTNR_in;
    assign btnRaw[BTN_U] = BTNU_in;
    assign btnRaw[BTN_D] = BTND_in;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : gBtn
        nexys4_btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) uDebounce (
            .clk_in  (clk_in),
            .reset   (reset),
            .btn_in  (btnRaw[i]),
            .pulse_o (btnPulse[i])
        );
    end

    // One action per cycle.  In EDIT the highest-priority pulse wins and the
    // others are simply lost; in COMMIT every pulse is ignored until the
    // consumer takes the word.
    always_comb begin
        state_d     = state_q;
        cursor_d    = cursor_q;
        editWord_d  = editWord_q;
        wordOut_d   = wordOut_q;
        wordValid_d = wordValid_q;

        if (state_q == ST_EDIT) begin
            if (btnPulse[BTN_D]) begin
                wordOut_d   = editWord_q;
                wordValid_d = 1'b1;
                state_d     = ST_COMMIT;
            end else if (btnPulse[BTN_U]) begin
                editWord_d[{cursor_q, 2'b00} +: 4] = SW_in;
            end else if (btnPulse[BTN_L]) begin
                cursor_d = cursor_q + cursor_t'(1);
            end else if (btnPulse[BTN_R]) begin
                cursor_d = cursor_q - cursor_t'(1);
            end
        end else begin
            if (wordValid_q && word_ready) begin
                wordValid_d = 1'b0;
                state_d     = ST_EDIT;
            end
        end

        cursorOnehot_d = NUM_DIGITS'(1) << cursor_d;
    end

    // The one-hot cursor is kept in its own register so the display sees a
    // flop output rather than a decoder.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q        <= ST_EDIT;
            cursor_q       <= '0;
            cursorOnehot_q <= NUM_DIGITS'(1);
            editWord_q     <= '0;
            wordOut_q      <= '0;
            wordValid_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cursor_q       <= cursor_d;
            cursorOnehot_q <= cursorOnehot_d;
            editWord_q     <= editWord_d;
            wordOut_q      <= wordOut_d;
            wordValid_q    <= wordValid_d;
        end
    end

    assign edit_word     = editWord_q;
    assign cursor_onehot = cursorOnehot_q;
    assign word_out      = wordOut_q;
    assign word_valid    = wordValid_q;

endmodule

// File: tb/tb_nexys4_word_entry.sv
// ---------------------------------------------------------------------------
// tb_nexys4_word_entry
// Self-checking bench for nexys4_word_entry with a short debounce window.
// Button codes in this bench: bit0 = L, bit1 = R, bit2 = U, bit3 = D.
// ---------------------------------------------------------------------------
module tb_nexys4_word_entry;

    localparam int DB     = 4;
    localparam int CW     = 3;
    localparam int HOLD   = 10;
    localparam int SETTLE = 10;

    localparam logic [3:0] B_L = 4'b0001;
    localparam logic [3:0] B_R = 4'b0010;
    localparam logic [3:0] B_U = 4'b0100;
    localparam logic [3:0] B_D = 4'b1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        BTNL_in = 1'b0;
    logic        BTNR_in = 1'b0;
    logic        BTNU_in = 1'b0;
    logic        BTND_in = 1'b0;
    logic [3:0]  SW_in = 4'h0;
    logic [31:0] edit_word;
    logic [7:0]  cursor_onehot;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ready = 1'b0;

    always #5 clk = ~clk;

    nexys4_word_entry #(
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (CW)
    ) dut (
        .clk_in        (clk),
        .reset         (reset),
        .BTNL_in       (BTNL_in),
        .BTNR_in       (BTNR_in),
        .BTNU_in       (BTNU_in),
        .BTND_in       (BTND_in),
        .SW_in         (SW_in),
        .edit_word     (edit_word),
        .cursor_onehot (cursor_onehot),
        .word_out      (word_out),
        .word_valid    (word_valid),
        .word_ready    (word_ready)
    );

    int checks = 0;
    int errors = 0;
    int validCycles;

    // Reference model: the word as an array of digits and a cursor position
    logic [3:0]  nib [8];
    int          mCursor;
    logic [31:0] mWord;
    logic        mValid;

    typedef struct {
        logic [3:0]  btn;
        logic [3:0]  sw;
        logic [31:0] expEdit;
        logic [7:0]  expCursor;
    } vec_t;

    vec_t tbl [16];

    function automatic logic [31:0] modelEdit();
        logic [31:0] w = 32'h0;
        for (int i = 0; i < 8; i++) w = w + (32'(nib[i]) << (4 * i));
        return w;
    endfunction

    function automatic logic [7:0] modelOnehot();
        logic [7:0] one = 8'h01;
        return one << mCursor;
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < 8; i++) nib[i] = 4'h0;
        mCursor = 0;
        mWord   = 32'h0;
        mValid  = 1'b0;
    endfunction

    // A press in EDIT performs the highest-priority action only
    function automatic void modelPress(input logic [3:0] btn, input logic [3:0] sw);
        if (mValid) return;
        if (btn[3]) begin
            mWord  = modelEdit();
            mValid = 1'b1;
        end else if (btn[2]) begin
            nib[mCursor] = sw;
        end else if (btn[0]) begin
            mCursor = (mCursor + 1) % 8;
        end else if (btn[1]) begin
            mCursor = (mCursor + 7) % 8;
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, " edit_word"}, edit_word, modelEdit());
        checkOutput({tag, " cursor_onehot"}, 32'(cursor_onehot), 32'(modelOnehot()));
        checkOutput({tag, " word_valid"}, 32'(word_valid), 32'(mValid));
        checkOutput({tag, " word_out"}, word_out, mWord);
    endtask

    // Holds the given buttons long enough to be accepted, releases them and
    // waits for the release to settle; counts cycles with word_valid high.
    task automatic applyStimulus(input logic [3:0] btn, input logic [3:0] sw);
        @(negedge clk);
        SW_in = sw;
        {BTND_in, BTNU_in, BTNR_in, BTNL_in} = btn;
        validCycles = 0;
        repeat (HOLD) begin
            @(negedge clk);
            if (word_valid) validCycles++;
        end
        {BTND_in, BTNU_in, BTNR_in, BTNL_in} = 4'b0000;
        repeat (SETTLE) begin
            @(negedge clk);
            if (word_valid) validCycles++;
        end
    endtask

    task automatic press(input logic [3:0] btn, input logic [3:0] sw);
        applyStimulus(btn, sw);
        modelPress(btn, sw);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        modelReset();
    endtask

    task automatic handshake();
        @(negedge clk);
        word_ready = 1'b1;
        @(negedge clk);
        word_ready = 1'b0;
        mValid = 1'b0;
    endtask

    initial begin
        logic [3:0]  btn;
        logic [3:0]  sw;
        logic [31:0] held;
        int          r;

        tbl[0]  = '{B_U, 4'hA, 32'h0000000A, 8'h01};
        tbl[1]  = '{B_L, 4'hA, 32'h0000000A, 8'h02};
        tbl[2]  = '{B_U, 4'hB, 32'h000000BA, 8'h02};
        tbl[3]  = '{B_L, 4'hB, 32'h000000BA, 8'h04};
        tbl[4]  = '{B_U, 4'hC, 32'h00000CBA, 8'h04};
        tbl[5]  = '{B_L, 4'hC, 32'h00000CBA, 8'h08};
        tbl[6]  = '{B_U, 4'hD, 32'h0000DCBA, 8'h08};
        tbl[7]  = '{B_L, 4'hD, 32'h0000DCBA, 8'h10};
        tbl[8]  = '{B_U, 4'hE, 32'h000EDCBA, 8'h10};
        tbl[9]  = '{B_L, 4'hE, 32'h000EDCBA, 8'h20};
        tbl[10] = '{B_U, 4'hF, 32'h00FEDCBA, 8'h20};
        tbl[11] = '{B_L, 4'hF, 32'h00FEDCBA, 8'h40};
        tbl[12] = '{B_U, 4'h1, 32'h01FEDCBA, 8'h40};
        tbl[13] = '{B_L, 4'h1, 32'h01FEDCBA, 8'h80};
        tbl[14] = '{B_U, 4'h2, 32'h21FEDCBA, 8'h80};
        tbl[15] = '{B_L, 4'h2, 32'h21FEDCBA, 8'h01};

        modelReset();
        repeat (3) @(negedge clk);
        doReset();
        repeat (20) @(negedge clk);
        checkAll("reset idle");

        // Digit entry walk across all eight nibbles, then the cursor wrap
        for (int i = 0; i < 16; i++) begin
            press(tbl[i].btn, tbl[i].sw);
            checkOutput($sformatf("table %0d edit_word", i), edit_word, tbl[i].expEdit);
            checkOutput($sformatf("table %0d cursor_onehot", i), 32'(cursor_onehot), 32'(tbl[i].expCursor));
        end

        // Bouncing U shorter than the debounce window must not write
        @(negedge clk);
        SW_in = 4'h7;
        for (int c = 0; c < 12; c++) begin
            BTNU_in = ((c % 3) != 2);
            @(negedge clk);
        end
        BTNU_in = 1'b0;
        repeat (SETTLE) @(negedge clk);
        checkAll("bounce");

        // Single R press from reset wraps the cursor to the top nibble
        doReset();
        press(B_R, 4'h0);
        checkAll("R wrap");

        // Enter DEADBEEF and commit with the consumer stalled
        doReset();
        press(B_U, 4'hF); press(B_L, 4'h0);
        press(B_U, 4'hE); press(B_L, 4'h0);
        press(B_U, 4'hE); press(B_L, 4'h0);
        press(B_U, 4'hB); press(B_L, 4'h0);
        press(B_U, 4'hD); press(B_L, 4'h0);
        press(B_U, 4'hA); press(B_L, 4'h0);
        press(B_U, 4'hE); press(B_L, 4'h0);
        press(B_U, 4'hD);
        checkOutput("deadbeef edit_word", edit_word, 32'hDEADBEEF);
        press(B_D, 4'h0);
        checkOutput("commit word_out", word_out, 32'hDEADBEEF);
        checkOutput("commit word_valid", 32'(word_valid), 32'd1);
        press(B_U, 4'h3);
        press(B_L, 4'h3);
        repeat (10) @(negedge clk);
        checkAll("stalled commit");
        handshake();
        checkAll("handshake done");
        press(B_L, 4'h0);
        checkAll("back in edit");

        // Simultaneous presses: U beats L, D beats U
        press(B_U | B_L, 4'h5);
        checkAll("U+L");
        press(B_D | B_U, 4'h9);
        checkAll("D+U");
        handshake();
        checkAll("D+U handshake");

        // Consumer already ready: valid lasts exactly one cycle
        @(negedge clk);
        word_ready = 1'b1;
        held = modelEdit();
        applyStimulus(B_D, 4'h0);
        word_ready = 1'b0;
        checkOutput("ready-early valid cycles", 32'(validCycles), 32'd1);
        checkOutput("ready-early word_out", word_out, held);
        mWord = held;
        checkAll("ready-early");

        // Reset while a word is pending discards it
        press(B_D, 4'h0);
        checkOutput("pending valid", 32'(word_valid), 32'd1);
        doReset();
        checkAll("reset mid-commit");

        // Random button traffic, including simultaneous presses
        for (int n = 0; n < 40; n++) begin
            r  = $urandom_range(0, 19);
            sw = 4'($urandom_range(0, 15));
            if (r < 5)       btn = B_L;
            else if (r < 8)  btn = B_R;
            else if (r < 15) btn = B_U;
            else if (r < 17) btn = B_D;
            else             btn = 4'($urandom_range(1, 15));
            press(btn, sw);
            checkAll($sformatf("random %0d", n));
            if (mValid) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                handshake();
                checkOutput($sformatf("random %0d release", n), 32'(word_valid), 32'd0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
